// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner. Walks an active-low row strobe
//                across the matrix, samples the synchronized columns at the
//                end of every row dwell, classifies each complete frame as
//                none / single key / multiple keys, and debounces presses
//                and releases over DEBOUNCE_COUNT consecutive frames.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_BITS      = 15,  // row dwell = 2**SCAN_BITS clocks
  parameter int DEBOUNCE_COUNT = 4    // identical frames to accept press/release
) (
  input  logic       clock,
  input  logic       reset,        // asynchronous, active low
  input  logic [3:0] col_in,       // active-low columns, asynchronous
  output logic [3:0] row_signals,  // active-low, one row low at a time
  output logic [3:0] key_code,     // row*4 + col of last accepted key
  output logic       key_valid,    // one-clock pulse per accepted press
  output logic       key_held      // high while the accepted key is down
);

  // Debounce counter only has to reach DEBOUNCE_COUNT, never beyond it.
  localparam int                CNT_W     = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CNT_W-1:0]  DB_TARGET = CNT_W'(DEBOUNCE_COUNT);
  localparam logic [CNT_W-1:0]  DB_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Scan timing
  // --------------------------------------------------------------------------
  logic                 scan_en_q;   // low only until the first clock after reset
  logic [SCAN_BITS-1:0] scan_cnt_q;
  logic [1:0]           row_q;
  logic                 row_end;     // last clock of a row dwell
  logic                 frame_end;   // last clock of row 3 dwell

  assign row_end   = scan_en_q && (scan_cnt_q == {SCAN_BITS{1'b1}});
  assign frame_end = row_end && (row_q == 2'd3);

  // Dwell counter and row index; both held at zero until scanning starts so
  // that row 0 gets a full dwell on the first clock after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_en_q  <= 1'b0;
      scan_cnt_q <= '0;
      row_q      <= 2'd0;
    end else begin
      scan_en_q <= 1'b1;
      if (scan_en_q) begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
        if (row_end) begin
          row_q <= row_q + 2'd1;
        end
      end
    end
  end

  // Row drive is all-high (no row selected) while held in reset.
  assign row_signals = scan_en_q ? ~(4'b1000 >> row_q) : 4'b1111;

  // --------------------------------------------------------------------------
  // Column synchronizer
  // --------------------------------------------------------------------------
  logic [3:0] col_meta_q;
  logic [3:0] col_sync_q;

  // Two-flop synchronizer; resets to the idle (pulled-up) level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Frame classification
  // --------------------------------------------------------------------------
  // Hit counts saturate at 2: anything above one key is simply "multi".
  logic [1:0] frame_hits_q;
  logic [3:0] frame_code_q;
  logic [3:0] row_act;      // bit c set when column c is active this row
  logic [1:0] row_hits;
  logic [1:0] row_col;
  logic [1:0] sum_hits;
  logic [3:0] sum_code;

  // Column c is wired to col_in[3-c].
  assign row_act = {~col_sync_q[0], ~col_sync_q[1], ~col_sync_q[2], ~col_sync_q[3]};

  // Count active columns in the current row and merge with the frame so far.
  always_comb begin
    row_hits = 2'd0;
    row_col  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (row_act[c]) begin
        row_col = 2'(c);
        if (row_hits != 2'd2) begin
          row_hits = row_hits + 2'd1;
        end
      end
    end

    if (row_hits == 2'd0) begin
      sum_hits = frame_hits_q;
    end else if (frame_hits_q == 2'd0) begin
      sum_hits = row_hits;
    end else begin
      sum_hits = 2'd2;
    end

    sum_code = (frame_hits_q != 2'd0) ? frame_code_q : {row_q, row_col};
  end

  // Accumulate hits across the four row samples; cleared as each frame closes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_hits_q <= 2'd0;
      frame_code_q <= 4'd0;
    end else if (row_end) begin
      if (frame_end) begin
        frame_hits_q <= 2'd0;
        frame_code_q <= 4'd0;
      end else begin
        frame_hits_q <= sum_hits;
        frame_code_q <= sum_code;
      end
    end
  end

  logic frame_none;
  logic frame_single;
  assign frame_none   = (sum_hits == 2'd0);
  assign frame_single = (sum_hits == 2'd1);

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [3:0]       cand_q,      cand_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q,  key_held_d;
  logic [CNT_W-1:0] cnt_inc;

  // cnt_q stays below DB_TARGET in DEBOUNCE/RELEASE, so the increment fits.
  assign cnt_inc = cnt_q + DB_ONE;

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic; decisions are taken only as a frame completes.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_single) begin
            cand_d = sum_code;
            cnt_d  = DB_ONE;
            if (DB_ONE == DB_TARGET) begin
              key_code_d  = sum_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end

        ST_DEBOUNCE: begin
          if (frame_single && (sum_code == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = ST_PRESSED;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_PRESSED: begin
          // Any key (including rollover) keeps the current press alive.
          if (frame_none) begin
            cnt_d = DB_ONE;
            if (DB_ONE == DB_TARGET) begin
              key_held_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end

        ST_RELEASE: begin
          if (frame_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              key_held_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end else begin
            // Bounce back to held without reporting a new press.
            state_d = ST_PRESSED;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire
